// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the MEM/WB pipeline stage.
//   mem_wb_t      : MEM/WB payload at the default 32-bit data / 5-bit index widths
//   skid_state_e  : occupancy of the stage buffer (EMPTY, ONE, TWO)
//   REG_X0        : index of the hard-wired zero register
package pipe_pkg;

   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned DEF_REG_ADDR_W = 5;
   localparam int unsigned REG_X0         = 0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]     data;
      logic                      reg_w;
      logic [DEF_REG_ADDR_W-1:0] reg_d;
      logic                      mem_r;
   } mem_wb_t;

endpackage

// File: rtl/skid_buf.sv
// skid_buf: generic valid/ready stage register with optional 2-entry skid.
//   clk_i, reset_i (sync, active-low), flush_i (drop all held entries)
//   in_valid_i / in_ready_o / in_data_i   : upstream handshake and payload
//   out_valid_o / out_ready_i / out_data_o : downstream handshake and payload
// SKID!=0: ready is derived from state only. SKID==0: one entry, ready
// passes out_ready_i through combinationally, so state TWO is unreachable.
module skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned SKID = 1
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   skid_state_e state_q, state_d;
   logic [W-1:0] main_q, skid_q;
   logic         in_fire, out_fire;
   logic         load_main, load_skid, main_from_skid;

   assign out_valid_o = (state_q != EMPTY);
   assign in_ready_o  = (SKID != 0) ? (state_q != TWO)
                                    : ((state_q == EMPTY) || out_ready_i);
   assign out_data_o  = main_q;
   assign in_fire     = in_valid_i && in_ready_o;
   assign out_fire    = out_valid_o && out_ready_i;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               load_main = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = TWO;
            end else if (out_fire) begin
               state_d   = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush drops both held and incoming entries; main keeps its old
      // contents so the payload outputs simply hold.
      if (flush_i) begin
         state_d        = EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) begin
            main_q <= in_data_i;
         end else if (main_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data_i;
         end
      end
   end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: parametrised MEM/WB pipeline register.
//   clk_i, reset_i (sync, active-low), flush_i
//   in_valid_i/in_ready_o with data_to_reg_i, reg_w_i, reg_d_i, mem_r_i
//   out_valid_o/out_ready_i with data_to_reg_o, reg_w_o, reg_d_o, mem_r_o
//   stall_cnt_o : saturating count of cycles with valid output not consumed
// Writes to x0 are stripped of their enable on capture.
module mem_wb_pipe_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned SKID       = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_W-1:0]     data_to_reg_i,
   input  logic                  reg_w_i,
   input  logic [REG_ADDR_W-1:0] reg_d_i,
   input  logic                  mem_r_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_W-1:0]     data_to_reg_o,
   output logic                  reg_w_o,
   output logic [REG_ADDR_W-1:0] reg_d_o,
   output logic                  mem_r_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   // Same layout as pipe_pkg::mem_wb_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_W-1:0]     data;
      logic                  reg_w;
      logic [REG_ADDR_W-1:0] reg_d;
      logic                  mem_r;
   } entry_t;

   entry_t in_e, out_e;
   logic [CNT_W-1:0] stall_q;

   always_comb begin
      in_e.data  = data_to_reg_i;
      in_e.reg_w = reg_w_i && (reg_d_i != REG_ADDR_W'(REG_X0));
      in_e.reg_d = reg_d_i;
      in_e.mem_r = mem_r_i;
   end

   skid_buf #(
      .W    ($bits(entry_t)),
      .SKID (SKID)
   ) u_skid_buf (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_e),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_e)
   );

   assign data_to_reg_o = out_e.data;
   assign reg_w_o       = out_e.reg_w;
   assign reg_d_o       = out_e.reg_d;
   assign mem_r_o       = out_e.mem_r;
   assign stall_cnt_o   = stall_q;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         stall_q <= '0;
      end else if (out_valid_o && !out_ready_i && !flush_i && (stall_q != '1)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench: a SKID=1 instance (default widths) and a SKID=0 instance (CNT_W=4)
// share one stimulus stream; each is compared to a FIFO reference model.
module tb_mem_wb_pipe_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready, flush, reg_w, mem_r;
   logic [31:0] data;
   logic [4:0]  reg_d;

   logic        ir1, ov1, rw1, mr1, ir0, ov0, rw0, mr0;
   logic [31:0] d1, d0;
   logic [4:0]  rd1, rd0;
   logic [15:0] sc1;
   logic [3:0]  sc0;

   int n_assert = 0;
   int n_fail   = 0;

   // Model index 0 = SKID=0 instance, index 1 = SKID=1 instance.
   // Entry layout: [38:7] data, [6] reg_w, [5:1] reg_d, [0] mem_r.
   logic [38:0] ent  [2][2];
   logic [38:0] last [2];
   int unsigned cnt  [2];
   int unsigned sc   [2];
   int unsigned smax [2];
   bit          acc  [2];

   always #5 clk = ~clk;

   mem_wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1), .CNT_W(16)) dut1 (
      .clk_i(clk), .reset_i(rst_n), .in_valid_i(in_valid), .in_ready_o(ir1),
      .data_to_reg_i(data), .reg_w_i(reg_w), .reg_d_i(reg_d), .mem_r_i(mem_r),
      .flush_i(flush), .out_valid_o(ov1), .out_ready_i(out_ready),
      .data_to_reg_o(d1), .reg_w_o(rw1), .reg_d_o(rd1), .mem_r_o(mr1),
      .stall_cnt_o(sc1));

   mem_wb_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID(0), .CNT_W(4)) dut0 (
      .clk_i(clk), .reset_i(rst_n), .in_valid_i(in_valid), .in_ready_o(ir0),
      .data_to_reg_i(data), .reg_w_i(reg_w), .reg_d_i(reg_d), .mem_r_i(mem_r),
      .flush_i(flush), .out_valid_o(ov0), .out_ready_i(out_ready),
      .data_to_reg_o(d0), .reg_w_o(rw0), .reg_d_o(rd0), .mem_r_o(mr0),
      .stall_cnt_o(sc0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [31:0] d, input logic [4:0] rd, input logic rw, input logic mr);
      in_valid = 1'b1;
      data     = d;
      reg_d    = rd;
      reg_w    = rw;
      mem_r    = mr;
   endtask

   // One clock: check both instances against the model, then advance the model.
   task automatic step(input bit do_chk);
      bit          rdy [2];
      bit          ifire, ofire;
      logic [38:0] ine;
      #1;
      rdy[0] = (cnt[0] == 0) || out_ready;
      rdy[1] = (cnt[1] < 2);
      if (do_chk) begin
         chk("s0_valid", 32'(ov0), 32'(cnt[0] != 0));
         chk("s0_ready", 32'(ir0), 32'(rdy[0]));
         chk("s0_data",  d0, last[0][38:7]);
         chk("s0_reg_w", 32'(rw0), 32'(last[0][6]));
         chk("s0_reg_d", 32'(rd0), 32'(last[0][5:1]));
         chk("s0_mem_r", 32'(mr0), 32'(last[0][0]));
         chk("s0_stall", 32'(sc0), sc[0]);
         chk("s1_valid", 32'(ov1), 32'(cnt[1] != 0));
         chk("s1_ready", 32'(ir1), 32'(rdy[1]));
         chk("s1_data",  d1, last[1][38:7]);
         chk("s1_reg_w", 32'(rw1), 32'(last[1][6]));
         chk("s1_reg_d", 32'(rd1), 32'(last[1][5:1]));
         chk("s1_mem_r", 32'(mr1), 32'(last[1][0]));
         chk("s1_stall", 32'(sc1), sc[1]);
      end
      ine = {data, reg_w && (reg_d != 5'd0), reg_d, mem_r};
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         ifire  = in_valid && rdy[k];
         ofire  = (cnt[k] != 0) && out_ready;
         acc[k] = ifire && rst_n && !flush;
         if (!rst_n) begin
            cnt[k]  = 0;
            sc[k]   = 0;
            last[k] = '0;
         end else if (flush) begin
            cnt[k] = 0;
         end else begin
            if (cnt[k] != 0 && !out_ready && sc[k] < smax[k]) sc[k]++;
            if (ofire) begin
               ent[k][0] = ent[k][1];
               cnt[k]--;
            end
            if (ifire) begin
               ent[k][cnt[k]] = ine;
               cnt[k]++;
            end
         end
         if (cnt[k] != 0) last[k] = ent[k][0];
      end
   endtask

   // Present the current input until the SKID=1 instance takes it (bounded).
   task automatic until_acc1();
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step(1);
         got = acc[1];
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      smax[0] = 15;
      smax[1] = 65535;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0; sc[k] = 0; last[k] = '0; acc[k] = 1'b0;
      end
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      data = '0; reg_d = '0; reg_w = 1'b0; mem_r = 1'b0;

      // Reset for two cycles, then stream four entries with WB always ready.
      step(0);
      step(1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         put(32'h11 * i, 5'(i), 1'b1, 1'(i % 2));
         step(1);
      end
      in_valid = 1'b0;
      step(1);
      step(1);

      // Write to x0 keeps its data but loses the enable.
      put(32'hDEAD, 5'd0, 1'b1, 1'b0);
      step(1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("x0_valid", 32'(ov1), 32'd1);
      chk("x0_reg_w", 32'(rw1), 32'd0);
      chk("x0_data",  d1, 32'hDEAD);
      step(1);
      out_ready = 1'b1;
      step(1);

      // Backpressure: two entries fit, the third waits until WB drains.
      out_ready = 1'b0;
      put(32'hA1, 5'd7, 1'b1, 1'b1);
      step(1);
      put(32'hA2, 5'd8, 1'b0, 1'b0);
      step(1);
      put(32'hA3, 5'd9, 1'b1, 1'b0);
      #1;
      chk("bp_ready_low", 32'(ir1), 32'd0);
      step(1);
      step(1);
      step(1);
      out_ready = 1'b1;
      until_acc1();
      in_valid = 1'b0;
      repeat (4) step(1);

      // Flush with two held entries and a third on the input.
      out_ready = 1'b0;
      put(32'hB1, 5'd1, 1'b1, 1'b0);
      step(1);
      put(32'hB2, 5'd2, 1'b1, 1'b0);
      step(1);
      put(32'hB3, 5'd3, 1'b1, 1'b0);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("flush_valid", 32'(ov1), 32'd0);
      chk("flush_ready", 32'(ir1), 32'd1);
      out_ready = 1'b1;
      repeat (3) step(1);

      // Reset while holding one entry.
      out_ready = 1'b0;
      put(32'h55, 5'd5, 1'b1, 1'b1);
      step(1);
      in_valid = 1'b0;
      step(1);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", 32'(ov1), 32'd0);
      chk("rst_data",  d1, 32'd0);
      chk("rst_reg_w", 32'(rw1), 32'd0);
      chk("rst_reg_d", 32'(rd1), 32'd0);
      chk("rst_mem_r", 32'(mr1), 32'd0);
      chk("rst_stall", 32'(sc1), 32'd0);

      // SKID=0 instance: stall long enough to saturate its 4-bit counter.
      put(32'h66, 5'd6, 1'b1, 1'b0);
      step(1);
      in_valid = 1'b0;
      repeat (20) step(1);
      chk("sat_stall0", 32'(sc0), 32'd15);
      #1;
      chk("comb_ready_lo", 32'(ir0), 32'd0);
      out_ready = 1'b1;
      #1;
      chk("comb_ready_hi", 32'(ir0), 32'd1);
      step(1);
      step(1);

      // Random traffic; a presented entry is held until both instances take it.
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && !(acc[0] && acc[1]))) begin
            in_valid = 1'($urandom % 2);
            data     = $urandom;
            reg_d    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            reg_w    = 1'($urandom);
            mem_r    = 1'($urandom);
         end
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 25) == 0;
         rst_n     = ($urandom % 100) != 0;
         step(1);
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
